// File: rtl/fifo_stream_reader_if.sv
// Purpose: bundles the fifo_sync read port and the downstream valid/ready stream.
// Latency: none, wiring only.
// Backpressure: m_ready from the consumer throttles fifo_rd_en inside the reader.
`timescale 1ns/1ps

interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  // FIFO read port
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  // Output stream
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  // Reader side: pops the FIFO and drives the stream
  modport master (
    output fifo_rd_en,
    input  fifo_data_out,
    input  fifo_empty,
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  // FIFO plus consumer side
  modport slave (
    input  fifo_rd_en,
    output fifo_data_out,
    output fifo_empty,
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Purpose: pops fifo_sync into a 2-entry skid buffer, streams words with burst m_last and a word count.
// Latency: fifo_rd_en in cycle C gives m_valid with that word in cycle C+2 (empty buffer).
// Backpressure: m_ready low stops new pops once buffer plus in-flight reach 2; outputs hold.
`timescale 1ns/1ps

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] words_read
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  // Buffer: r_head is always the word on m_data, r_tail the second entry
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;
  logic                  r_infl;
  logic                  r_valid;
  logic                  r_last;
  logic [BEAT_W-1:0]     r_beat;
  logic [CNT_WIDTH-1:0]  r_words;

  logic                  w_pop;
  logic [2:0]            w_level;
  logic [1:0]            w_occ_nxt;
  logic                  w_valid_nxt;
  logic [BEAT_W-1:0]     w_beat_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_tail_nxt;

  // Next-state for buffer, occupancy and burst position; the occupancy after
  // this edge doubles as the read-issue headroom test
  always_comb begin
    w_pop       = r_valid & bus.m_ready;
    w_level     = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    w_occ_nxt   = w_level[1:0];
    w_valid_nxt = (w_occ_nxt != 2'd0);
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    if (r_infl) begin
      if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop)) begin
        w_head_nxt = bus.fifo_data_out;
      end else if (r_occ == 2'd1) begin
        w_tail_nxt = bus.fifo_data_out;
      end else begin
        // occ==2 with a capture only happens alongside a pop
        w_head_nxt = r_tail;
        w_tail_nxt = bus.fifo_data_out;
      end
    end else if (w_pop && (r_occ == 2'd2)) begin
      w_head_nxt = r_tail;
    end
    w_beat_nxt = r_beat;
    if (w_pop) begin
      w_beat_nxt = (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
    end
  end

  // Pop only when the FIFO has data and the buffer can absorb the word;
  // gated by rst_n so nothing is popped while held in reset
  assign bus.fifo_rd_en = rst_n & enable & ~bus.fifo_empty & (w_level < 3'd2);

  // Registered state and outputs; reset drops buffered and in-flight words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= 2'd0;
      r_infl  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_beat  <= '0;
      r_words <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_occ   <= w_occ_nxt;
      r_infl  <= bus.fifo_rd_en;
      r_valid <= w_valid_nxt;
      r_last  <= w_valid_nxt && (w_beat_nxt == LAST_BEAT);
      r_beat  <= w_beat_nxt;
      if (w_pop) begin
        r_words <= r_words + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.m_data  = r_head;
  assign bus.m_valid = r_valid;
  assign bus.m_last  = r_last;
  assign words_read  = r_words;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Purpose: directed checks of fifo_stream_reader against a behavioural fifo_sync model.
// Latency: model FIFO returns data the cycle after a sampled fifo_rd_en.
// Backpressure: m_ready is driven directly by the stimulus.
`timescale 1ns/1ps

module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] words_read;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus();

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus),
    .words_read (words_read)
  );

  always #5 clk = ~clk;

  // Behavioural fifo_sync: data_out registered one edge after rd_en
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_data_out <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor on the falling edge: handshakes, pops, pops of an empty FIFO
  logic [7:0] obs_d [$];
  logic       obs_l [$];
  int         hs_cyc [$];
  int         pop_cnt = 0;
  int         bad_rd = 0;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        obs_d.push_back(bus.m_data);
        obs_l.push_back(bus.m_last);
        hs_cyc.push_back(cyc);
      end
      if (bus.fifo_rd_en) pop_cnt = pop_cnt + 1;
      if (bus.fifo_rd_en && bus.fifo_empty) bad_rd = bad_rd + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Bounded wait for a number of observed handshakes; a timeout shows up as a count mismatch
  task automatic wait_obs(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (obs_d.size() >= target) break;
      step(1);
    end
    check_eq({tag, "_count"}, obs_d.size(), target);
  endtask

  // Compare n observed words against first, first+1, ... with m_last on every 4th beat
  task automatic check_seq(input string tag, input int base, input int n, input logic [7:0] first);
    logic [31:0] got_d;
    logic [31:0] got_l;
    for (int i = 0; i < n; i++) begin
      got_d = 32'hFFFF_FFFF;
      got_l = 32'hFFFF_FFFF;
      if (base + i < obs_d.size()) begin
        got_d = {24'h0, obs_d[base + i]};
        got_l = {31'h0, obs_l[base + i]};
      end
      check_eq($sformatf("%s_data%0d", tag, i), got_d, {24'h0, first + 8'(i)});
      check_eq($sformatf("%s_last%0d", tag, i), got_l, {31'h0, (i % 4) == 3});
    end
  endtask

  initial begin
    int base_o;
    int base_p;
    int c_rd;
    int c_v;

    // Reset with a non-empty FIFO: nothing may be popped, outputs all zero
    bus.m_ready = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    step(2);
    check_eq("rst_rd_en", bus.fifo_rd_en, 0);
    check_eq("rst_valid", bus.m_valid, 0);
    check_eq("rst_last", bus.m_last, 0);
    check_eq("rst_data", bus.m_data, 0);
    check_eq("rst_words", words_read, 0);

    // Streaming with no backpressure
    base_o = obs_d.size();
    rst_n = 1'b1;
    wait_obs("stream", base_o + 8, 40);
    check_seq("stream", base_o, 8, 8'h01);
    if (hs_cyc.size() >= base_o + 8)
      check_eq("stream_back2back", hs_cyc[base_o + 7] - hs_cyc[base_o], 7);
    else
      check_eq("stream_back2back", 32'hFFFF_FFFF, 7);
    check_eq("stream_words", words_read, 8);
    check_eq("stream_no_empty_pop", bad_rd, 0);

    // Backpressure: only two pops, head held stable
    bus.m_ready = 1'b0;
    base_o = obs_d.size();
    base_p = pop_cnt;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    step(10);
    check_eq("bp_pops", pop_cnt - base_p, 2);
    check_eq("bp_valid", bus.m_valid, 1);
    check_eq("bp_data", bus.m_data, 8'h01);
    check_eq("bp_last", bus.m_last, 0);
    step(5);
    check_eq("bp_data_hold", bus.m_data, 8'h01);
    check_eq("bp_pops_hold", pop_cnt - base_p, 2);
    bus.m_ready = 1'b1;
    wait_obs("bp", base_o + 8, 40);
    check_seq("bp", base_o, 8, 8'h01);
    check_eq("bp_words", words_read, 16);

    // Random m_ready stalls and enable toggling
    base_o = obs_d.size();
    for (int i = 0; i < 32; i++) push_word(8'h10 + 8'(i));
    for (int i = 0; i < 2000; i++) begin
      if (obs_d.size() >= base_o + 32) break;
      enable = ($urandom_range(0, 3) != 0);
      bus.m_ready = $urandom_range(0, 1) != 0;
      step(1);
    end
    enable = 1'b1;
    bus.m_ready = 1'b1;
    check_eq("rand_count", obs_d.size(), base_o + 32);
    check_seq("rand", base_o, 32, 8'h10);
    check_eq("rand_words", words_read, 48);
    check_eq("rand_no_empty_pop", bad_rd, 0);

    // Single word into an empty FIFO: m_valid two cycles after the pop
    step(3);
    base_o = obs_d.size();
    base_p = pop_cnt;
    c_rd = -1;
    c_v = -1;
    push_word(8'h10);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en && c_rd < 0) c_rd = c;
      if (bus.m_valid && c_v < 0) c_v = c;
    end
    @(posedge clk);
    #2;
    check_eq("single_rd_seen", c_rd, 0);
    check_eq("single_latency", c_v - c_rd, 2);
    check_eq("single_pops", pop_cnt - base_p, 1);
    check_eq("single_count", obs_d.size(), base_o + 1);
    if (obs_d.size() > base_o) check_eq("single_data", obs_d[base_o], 8'h10);
    else check_eq("single_data", 32'hFFFF_FFFF, 8'h10);
    check_eq("single_no_empty_pop", bad_rd, 0);

    // Mid-burst reset after two beats, one word buffered and one in flight
    base_o = obs_d.size();
    for (int i = 0; i < 8; i++) push_word(8'h41 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      if (obs_d.size() >= base_o + 2) break;
      step(1);
    end
    check_eq("mr_pre_valid", bus.m_valid, 1);
    check_eq("mr_pre_words", words_read, 51);
    rst_n = 1'b0;
    #1;
    check_eq("mr_valid", bus.m_valid, 0);
    check_eq("mr_data", bus.m_data, 0);
    check_eq("mr_last", bus.m_last, 0);
    check_eq("mr_words", words_read, 0);
    check_eq("mr_rd_en", bus.fifo_rd_en, 0);
    step(2);
    base_o = obs_d.size();
    rst_n = 1'b1;
    wait_obs("mr_after", base_o + 4, 30);
    check_seq("mr_after", base_o, 4, 8'h45);
    check_eq("mr_after_words", words_read, 4);
    check_eq("mr_no_empty_pop", bad_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side master for `fifo_sync`. Pops words from the FIFO's `rd_en`/`data_out`/`empty` port and presents them on a valid/ready stream with a 2-entry output buffer, so a 1-cycle FIFO read latency never causes underflow, data loss or throughput bubbles. Groups output beats into fixed-length bursts with a `m_last` marker and keeps a running count of delivered words. Sits between `fifo_sync` and any downstream stream consumer.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; equal to the FIFO's `DATA_WIDTH`.
- `BURST_LEN`, 4: beats per burst; `m_last` marks every `BURST_LEN`-th beat; legal range is 1 to 256.
- `CNT_WIDTH`, 16: width of `words_read`.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new FIFO reads while high.
- `fifo_rd_en`  out  1  pop request to the FIFO `rd_en`; combinational.
- `fifo_data_out`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after a pop.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `m_data`  out  DATA_WIDTH  output word; registered.
- `m_valid`  out  1  output word valid; registered.
- `m_ready`  in  1  downstream accepts the word.
- `m_last`  out  1  the current beat is the final beat of its burst.
- `words_read`  out  CNT_WIDTH  total handshakes since reset; wraps to 0.

## Operation
- Pop (handshake): `m_valid && m_ready` in the same cycle.
- Output buffer: a 2-entry FIFO of words. `m_data` always shows the head entry. `occ` is the buffer occupancy, 0 to 2.
- In-flight flag: `infl` is a register set to the previous cycle's `fifo_rd_en`.
- Read issue: `fifo_rd_en = enable && !fifo_empty && (occ + infl - pop) < 2`.
  - This rule never pops an empty FIFO.
  - This rule never overflows the output buffer.
  - `m_ready` reaches `fifo_rd_en` through combinational logic only; there is no path from `fifo_rd_en` back to `m_ready`.
- Capture: when `infl` is 1, `fifo_data_out` is written into the buffer at the clock edge. The pop and capture of one edge are applied together:
  - new `occ` = `occ` + `infl` − `pop`
  - a capture into an empty buffer appears at the head.
- `m_valid` = (`occ` != 0).
- Burst counter `beat`, range 0 to `BURST_LEN`−1:
  - increments on each handshake and wraps to 0 after `BURST_LEN`−1.
  - `m_last` = `m_valid && beat == BURST_LEN-1`.
  - With `BURST_LEN`=1, `m_last` equals `m_valid`.
- `words_read` increments on each handshake, modulo 2^`CNT_WIDTH`.
- `enable` deasserted:
  - no new reads are issued.
  - words already buffered or in flight are still delivered.
  - `beat` is preserved.
- `m_valid` high with `m_ready` low: `m_data`, `m_valid` and `m_last` hold stable until the handshake.
- Reset, whether idle or mid-burst, applies asynchronously:
  - `occ`, `infl`, `beat` and `words_read` go to 0.
  - `m_valid`, `m_last` and `m_data` go to 0.
  - `fifo_rd_en` is 0 while `rst_n` is low.
  - In-flight words are discarded.

## Timing
- FIFO contract: `fifo_rd_en` sampled at edge N makes `fifo_data_out` valid after edge N; the word is captured at edge N+1.
- Latency: `fifo_rd_en` high in cycle C gives `m_valid` high with that word in cycle C+2, provided the buffer was empty.
- Sustained throughput is 1 word/cycle when `m_ready` is held high and the FIFO stays non-empty.
- When `m_ready` is held low, at most 2 pops are issued; after that `fifo_rd_en` stays 0.
- Order is strictly FIFO: words leave in the same order they were popped.

## Test plan
- Reset, then check idle state: all outputs 0; `fifo_rd_en`=0 even with `fifo_empty`=0 while `rst_n`=0.
- Streaming, no backpressure:
  - Stimulus: preload the FIFO with 01..08; `enable`=1; `m_ready`=1.
  - Required: 8 consecutive handshakes carrying 01..08.
  - Required: `m_last` high on 04 and 08.
  - Required: `words_read`=8.
  - Required: `fifo_rd_en` never high while `fifo_empty`=1.
- Backpressure:
  - Stimulus: `m_ready`=0 with 8 words in the FIFO.
  - Required: exactly 2 pops; `m_data`=01 held stable.
  - Stimulus: release `m_ready`.
  - Required: 01..08 delivered with no loss and no duplicates.
- Random `m_ready` stalls:
  - Stimulus: 10H..2FH with random `m_ready` and random `enable` toggling.
  - Required: output sequence matches the input sequence exactly.
  - Required: `m_last` on every 4th beat.
- FIFO empty, single word:
  - Stimulus: write 10H into an empty FIFO.
  - Required: `m_valid` rises 2 cycles after `fifo_rd_en`.
  - Required: no further `fifo_rd_en` while `fifo_empty`=1.
- Mid-burst reset:
  - Stimulus: assert `rst_n` low after 2 beats, with 1 word buffered and 1 in flight.
  - Required: outputs clear immediately.
  - Required: after release, the next delivered word restarts at `beat`=0 and `words_read` counts from 0.
